mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single physical memory port between the fetch requester (IF, read-only) and the load/store requester (LS, read/write).
//  Sits between the fetch/MEM pipeline stages and the pmem/cache port.
//  Runs one transaction at a time: latch request, hold it until accepted, wait for response, route it back.
//  LS has priority; a streak counter stops IF from starving.
// PARAMETERS
//  ADDR_W         32  address width of all requesters and the port
//  DATA_W         64  data width (doubly-aligned words)
//  MAX_LS_STREAK   4  consecutive LS grants allowed while IF waits before IF is forced to win
// PORTS
//  clk        in   1           clock
//  rst        in   1           reset, synchronous, active-high
//  if_req     in   1           IF read request
//  if_addr    in   ADDR_W      IF address
//  if_flush   in   1           discard any outstanding IF response
//  if_ready   out  1           IF request accepted this cycle
//  if_rvalid  out  1           IF response valid (1-cycle pulse)
//  if_rdata   out  DATA_W      IF response data
//  ls_req     in   1           LS request
//  ls_we      in   1           1=store, 0=load
//  ls_addr    in   ADDR_W      LS address
//  ls_wdata   in   DATA_W      store data
//  ls_wmask   in   8           store byte mask
//  ls_ready   out  1           LS request accepted this cycle
//  ls_rvalid  out  1           LS response valid: load data, or store completion
//  ls_rdata   out  DATA_W      LS load data
//  mem_req    out  1           port request
//  mem_we     out  1           port write enable
//  mem_addr   out  ADDR_W      port address
//  mem_wdata  out  DATA_W      port write data
//  mem_wmask  out  8           port write mask
//  mem_gnt    in   1           port accepted the request
//  mem_rvalid in   1           port response; one per accepted request, at least 1 cycle after mem_gnt
//  mem_rdata  in   DATA_W      port read data
//  busy       out  1           state != IDLE
// BEHAVIOUR
//  Reset values: state=IDLE; streak=0; drop=0.
//    All outputs are 0; mem_* fields are 0.
//  FSM states: IDLE, REQ_IF, WAIT_IF, REQ_LS, WAIT_LS.
//  IDLE: the grant decision is combinational.
//    LS wins if ls_req && !(if_req && streak==MAX_LS_STREAK).
//    Otherwise IF wins if if_req && !if_flush.
//    The winner's ready is high for that cycle only.
//    Its fields are latched into the request register; go to REQ_x.
//  REQ_x: mem_req=1 with the latched fields held stable until mem_gnt, then go to WAIT_x.
//    If mem_gnt is high in the first REQ cycle, WAIT_x is entered next cycle.
//  WAIT_x: on mem_rvalid, pulse x_rvalid; x_rdata=mem_rdata (combinational pass-through); go to IDLE.
//    ls_rvalid also pulses for stores; ls_rdata is don't-care for stores.
//  Minimum round trip: accept at T, mem_req at T+1 (gnt), rvalid at T+2, next accept at T+3.
//  Streak counter:
//    +1 on each LS grant while if_req=1, saturating at MAX_LS_STREAK.
//    Cleared on an IF grant, or in any IDLE cycle with if_req=0.
//  Flush:
//    if_flush in REQ_IF/WAIT_IF sets drop. The transaction still completes on the port.
//    With drop=1, if_rvalid is suppressed at mem_rvalid; drop clears on return to IDLE.
//    if_flush in IDLE blocks the IF grant that cycle.
//  If ls_req and if_req are both high, LS wins unless streak saturated. The loser holds its request; its ready stays 0.
//  Requesters hold req and fields stable until ready. A dropped req never produces a response.
//  Unexpected mem_rvalid in IDLE/REQ_x: ignored, no response pulse.
//  Reset mid-transaction: IDLE next edge, mem_req=0, no responses emitted, streak=0.
// STRUCTURE
//  Shared header: add state encodings (3'd0..3'd4) and MEM_ARB_* width defines to ysyx_22040127_mycpu.v.
//  Single module, no sub-modules. One registered request bundle plus a drop flag; the FSM and the streak counter are in the same file.
// TESTING
//  1 LS load alone, addr 0x80000008: ls_ready at T; mem_req at T+1; gnt at T+1; rvalid 0xDEAD at T+3 -> ls_rvalid=1, ls_rdata=0xDEAD at T+3; busy=0 at T+4.
//  2 if_req and ls_req (store, wmask 0xF0) both high in IDLE: LS first, with mem_we=1, mem_wmask=0xF0; IF accepted in the first IDLE after ls_rvalid.
//  3 IF plus back-to-back LS reqs, MAX_LS_STREAK=4: exactly 4 LS grants, then an IF grant, then LS resumes.
//  4 if_flush in WAIT_IF: port rvalid arrives, if_rvalid stays 0; next IF request served normally.
//  5 mem_gnt held low 5 cycles: mem_req/mem_addr/mem_wdata stable all 5 cycles; no second ready issued.
//  6 rst in WAIT_LS: next cycle busy=0, mem_req=0; later mem_rvalid yields no ls_rvalid.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and FSM encoding for the memory port arbiter between the
// fetch (IF) and load/store (LS) requesters.
package mem_port_arbiter_pkg;

   localparam int MEM_ARB_ADDR_W        = 32;
   localparam int MEM_ARB_DATA_W        = 64;
   localparam int MEM_ARB_MASK_W        = 8;
   localparam int MEM_ARB_MAX_LS_STREAK = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ_IF  = 3'd1,
      ST_WAIT_IF = 3'd2,
      ST_REQ_LS  = 3'd3,
      ST_WAIT_LS = 3'd4
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IF and LS.
// LS has priority; a streak counter forces an IF win after MAX_LS_STREAK LS grants.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W        = MEM_ARB_ADDR_W,
   parameter int DATA_W        = MEM_ARB_DATA_W,
   parameter int MAX_LS_STREAK = MEM_ARB_MAX_LS_STREAK
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      if_req,
   input  logic [ADDR_W-1:0]         if_addr,
   input  logic                      if_flush,
   output logic                      if_ready,
   output logic                      if_rvalid,
   output logic [DATA_W-1:0]         if_rdata,
   input  logic                      ls_req,
   input  logic                      ls_we,
   input  logic [ADDR_W-1:0]         ls_addr,
   input  logic [DATA_W-1:0]         ls_wdata,
   input  logic [MEM_ARB_MASK_W-1:0] ls_wmask,
   output logic                      ls_ready,
   output logic                      ls_rvalid,
   output logic [DATA_W-1:0]         ls_rdata,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic [MEM_ARB_MASK_W-1:0] mem_wmask,
   input  logic                      mem_gnt,
   input  logic                      mem_rvalid,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      busy,
   output arb_state_e                state_dbg
);

   localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);

   // Handshake: x_ready is a one-cycle accept pulse while x_req is held;
   // the port holds mem_* stable under mem_req until mem_gnt.
   arb_state_e                state_q, state_d;
   logic [STREAK_W-1:0]       streak_q, streak_d;
   logic                      drop_q, drop_d;
   logic                      req_we_q, req_we_d;
   logic [ADDR_W-1:0]         req_addr_q, req_addr_d;
   logic [DATA_W-1:0]         req_wdata_q, req_wdata_d;
   logic [MEM_ARB_MASK_W-1:0] req_wmask_q, req_wmask_d;

   logic streak_sat, ls_win, if_win;

   assign streak_sat = (streak_q == STREAK_W'(MAX_LS_STREAK));
   assign ls_win     = ls_req && !(if_req && streak_sat);
   assign if_win     = !ls_win && if_req && !if_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         streak_q    <= '0;
         drop_q      <= 1'b0;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_wmask_q <= '0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         drop_q      <= drop_d;
         req_we_q    <= req_we_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_wmask_q <= req_wmask_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      drop_d      = drop_q;
      req_we_d    = req_we_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_wmask_d = req_wmask_q;
      if_ready    = 1'b0;
      ls_ready    = 1'b0;
      if_rvalid   = 1'b0;
      ls_rvalid   = 1'b0;
      mem_req     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ls_win) begin
               ls_ready    = 1'b1;
               req_we_d    = ls_we;
               req_addr_d  = ls_addr;
               req_wdata_d = ls_wdata;
               req_wmask_d = ls_wmask;
               state_d     = ST_REQ_LS;
               if (!if_req)
                  streak_d = '0;
               else if (!streak_sat)
                  streak_d = streak_q + STREAK_W'(1);
            end else if (if_win) begin
               if_ready    = 1'b1;
               req_we_d    = 1'b0;
               req_addr_d  = if_addr;
               req_wdata_d = '0;
               req_wmask_d = '0;
               state_d     = ST_REQ_IF;
               streak_d    = '0;
            end else if (!if_req) begin
               streak_d = '0;
            end
         end
         ST_REQ_IF, ST_REQ_LS: begin
            mem_req = 1'b1;
            if (mem_gnt)
               state_d = (state_q == ST_REQ_IF) ? ST_WAIT_IF : ST_WAIT_LS;
         end
         ST_WAIT_IF: begin
            // A flush arriving with the response discards it as well.
            if (mem_rvalid) begin
               if_rvalid = !(drop_q || if_flush);
               state_d   = ST_IDLE;
            end
         end
         ST_WAIT_LS: begin
            if (mem_rvalid) begin
               ls_rvalid = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_IDLE)
         drop_d = 1'b0;
      else if (if_flush && (state_q == ST_REQ_IF || state_q == ST_WAIT_IF))
         drop_d = 1'b1;
   end

   assign mem_we    = mem_req && req_we_q;
   assign mem_addr  = mem_req ? req_addr_q  : '0;
   assign mem_wdata = mem_req ? req_wdata_q : '0;
   assign mem_wmask = mem_req ? req_wmask_q : '0;
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign ls_rdata  = ls_rvalid ? mem_rdata : '0;
   assign busy      = (state_q != ST_IDLE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int AW   = 32;
   localparam int DW   = 64;
   localparam int MAXS = 4;
   localparam logic [7:0] G_LS = 8'h4C;
   localparam logic [7:0] G_IF = 8'h49;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          if_req, if_flush, if_ready, if_rvalid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          ls_req, ls_we, ls_ready, ls_rvalid;
   logic [AW-1:0] ls_addr;
   logic [DW-1:0] ls_wdata, ls_rdata;
   logic [7:0]    ls_wmask;
   logic          mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [7:0]    mem_wmask;
   logic          busy;
   arb_state_e    state_dbg;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LS_STREAK(MAXS)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_wmask(ls_wmask), .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .busy(busy), .state_dbg(state_dbg)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks: inputs change 1 unit after the edge, directed checks 1 unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 20) begin
         tick();
         look();
         n++;
      end
      chk(name, busy, 1'b0);
   endtask

   // auto-responding memory: grant immediately, respond the following cycle
   bit            auto_mem = 1'b0;
   bit            gnt_last = 1'b0;
   logic [DW-1:0] rd_cnt   = 64'h1000;

   always @(posedge clk) begin
      #1;
      if (auto_mem) begin
         mem_rvalid = gnt_last;
         mem_rdata  = gnt_last ? rd_cnt : '0;
         if (gnt_last) rd_cnt = rd_cnt + 1;
         mem_gnt  = mem_req;
         gnt_last = mem_req;
      end else begin
         gnt_last = 1'b0;
      end
   end

   // transaction-level reference: at most one transaction in flight
   bit            m_on = 1'b0, m_busy = 1'b0, m_ls = 1'b0, m_gnt = 1'b0, m_drop = 1'b0;
   int            m_streak = 0;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [7:0]    m_wmask;
   bit            ls_acc = 1'b0, if_acc = 1'b0;
   logic [7:0]    grant_q[$];
   logic [7:0]    exp_q[$];

   always @(negedge clk) begin
      bit e_lsr, e_ifr, e_lsv, e_ifv, e_mreq;
      e_lsr = 1'b0; e_ifr = 1'b0; e_lsv = 1'b0; e_ifv = 1'b0; e_mreq = 1'b0;
      if (!m_busy) begin
         e_lsr = ls_req && !(if_req && m_streak >= MAXS);
         e_ifr = !e_lsr && if_req && !if_flush;
      end else if (!m_gnt) begin
         e_mreq = 1'b1;
      end else if (mem_rvalid) begin
         if (m_ls) e_lsv = 1'b1;
         else      e_ifv = !(m_drop || if_flush);
      end
      if (m_on) begin
         chk("cmp_ls_ready", ls_ready, e_lsr);
         chk("cmp_if_ready", if_ready, e_ifr);
         chk("cmp_ls_rvalid", ls_rvalid, e_lsv);
         chk("cmp_if_rvalid", if_rvalid, e_ifv);
         chk("cmp_mem_req", mem_req, e_mreq);
         chk("cmp_busy", busy, m_busy);
         if (e_mreq) begin
            chk("cmp_mem_we", mem_we, m_we);
            chk("cmp_mem_addr", mem_addr, m_addr);
            chk("cmp_mem_wdata", mem_wdata, m_wdata);
            chk("cmp_mem_wmask", mem_wmask, m_wmask);
         end
         if (e_lsv && !m_we) chk("cmp_ls_rdata", ls_rdata, mem_rdata);
         if (e_ifv) chk("cmp_if_rdata", if_rdata, mem_rdata);
         if (ls_ready) grant_q.push_back(G_LS);
         if (if_ready) grant_q.push_back(G_IF);
      end
      ls_acc = ls_ready;
      if_acc = if_ready;
      if (rst) begin
         m_on = 1'b1; m_busy = 1'b0; m_gnt = 1'b0; m_drop = 1'b0; m_streak = 0;
      end else if (m_on) begin
         if (!m_busy) begin
            if (e_lsr) begin
               m_busy = 1'b1; m_ls = 1'b1; m_gnt = 1'b0;
               m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata; m_wmask = ls_wmask;
               m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end else if (e_ifr) begin
               m_busy = 1'b1; m_ls = 1'b0; m_gnt = 1'b0;
               m_we = 1'b0; m_addr = if_addr; m_wdata = '0; m_wmask = '0;
               m_streak = 0;
            end else if (!if_req) begin
               m_streak = 0;
            end
         end else if (!m_gnt) begin
            if (mem_gnt) m_gnt = 1'b1;
            if (!m_ls && if_flush) m_drop = 1'b1;
         end else if (mem_rvalid) begin
            m_busy = 1'b0; m_gnt = 1'b0; m_drop = 1'b0;
         end else if (!m_ls && if_flush) begin
            m_drop = 1'b1;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      if_req = 0; if_addr = '0; if_flush = 0;
      ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;

      // reset state
      repeat (2) tick();
      look();
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wmask", mem_wmask, '0);
      chk("rst_ls_rvalid", ls_rvalid, 1'b0);
      chk("rst_if_rvalid", if_rvalid, 1'b0);
      tick();
      rst = 1'b0;

      // 1: LS load alone
      tick(); ls_req = 1; ls_we = 0; ls_addr = 32'h8000_0008; look();
      chk("t1_ls_ready", ls_ready, 1'b1);
      tick(); ls_req = 0; mem_gnt = 1; look();
      chk("t1_mem_req", mem_req, 1'b1);
      chk("t1_mem_addr", mem_addr, 32'h8000_0008);
      chk("t1_mem_we", mem_we, 1'b0);
      tick(); mem_gnt = 0; look();
      chk("t1_wait_busy", busy, 1'b1);
      chk("t1_wait_mem_req", mem_req, 1'b0);
      tick(); mem_rvalid = 1; mem_rdata = 64'hDEAD; look();
      chk("t1_ls_rvalid", ls_rvalid, 1'b1);
      chk("t1_ls_rdata", ls_rdata, 64'hDEAD);
      tick(); mem_rvalid = 0; mem_rdata = '0; look();
      chk("t1_busy_after", busy, 1'b0);

      // 2: simultaneous IF and LS store, LS first
      auto_mem = 1'b1;
      tick(); if_req = 1; if_addr = 32'h1000;
      ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 64'h1122_3344_5566_7788; ls_wmask = 8'hF0;
      look();
      chk("t2_ls_ready", ls_ready, 1'b1);
      chk("t2_if_ready", if_ready, 1'b0);
      tick(); ls_req = 0; look();
      chk("t2_mem_we", mem_we, 1'b1);
      chk("t2_mem_wmask", mem_wmask, 8'hF0);
      chk("t2_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
      tick(); look();
      chk("t2_ls_rvalid", ls_rvalid, 1'b1);
      chk("t2_if_wait", if_ready, 1'b0);
      tick(); look();
      chk("t2_if_ready", if_ready, 1'b1);
      tick(); if_req = 0; look();
      chk("t2_if_mem_addr", mem_addr, 32'h1000);
      tick(); look();
      chk("t2_if_rvalid", if_rvalid, 1'b1);
      chk("t2_if_rdata", if_rdata, 64'h1001);
      wait_idle("t2_idle");

      // 3: LS streak limit with IF waiting
      grant_q.delete();
      tick(); if_req = 1; if_addr = 32'h3000;
      ls_req = 1; ls_we = 0; ls_addr = 32'h4000; ls_wmask = '0; ls_wdata = '0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (ls_acc) ls_addr = ls_addr + 8;
         if (if_acc) if_addr = if_addr + 8;
      end
      ls_req = 0; if_req = 0;
      look();
      wait_idle("t3_idle");
      exp_q = '{G_LS, G_LS, G_LS, G_LS, G_IF, G_LS};
      for (int i = 0; i < 6; i++)
         chk($sformatf("t3_grant%0d", i), (i < grant_q.size()) ? grant_q[i] : 8'h00, exp_q[i]);
      auto_mem = 1'b0;
      tick(); mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;

      // 4: flush blocks IF in IDLE, then flush in WAIT_IF drops the response
      tick(); if_req = 1; if_flush = 1; if_addr = 32'h5000; look();
      chk("t4_flush_blocks", if_ready, 1'b0);
      tick(); if_flush = 0; look();
      chk("t4_if_ready", if_ready, 1'b1);
      tick(); if_req = 0; mem_gnt = 1; look();
      chk("t4_mem_req", mem_req, 1'b1);
      tick(); mem_gnt = 0; if_flush = 1; look();
      chk("t4_wait_busy", busy, 1'b1);
      tick(); if_flush = 0; mem_rvalid = 1; mem_rdata = 64'hBEEF; look();
      chk("t4_dropped", if_rvalid, 1'b0);
      tick(); mem_rvalid = 0; if_req = 1; if_addr = 32'h5008; look();
      chk("t4_next_ready", if_ready, 1'b1);
      tick(); if_req = 0; mem_gnt = 1; look();
      chk("t4_next_addr", mem_addr, 32'h5008);
      tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'hCAFE; look();
      chk("t4_next_rvalid", if_rvalid, 1'b1);
      chk("t4_next_rdata", if_rdata, 64'hCAFE);
      tick(); mem_rvalid = 0; look();
      chk("t4_idle", busy, 1'b0);

      // 5: grant held off 5 cycles, stray rvalid while requesting
      tick(); ls_req = 1; ls_we = 1; ls_addr = 32'h6000; ls_wdata = 64'hA5A5_A5A5_0000_FFFF; ls_wmask = 8'h0F;
      look();
      chk("t5_ls_ready", ls_ready, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) begin
            ls_addr = 32'h6008; ls_wdata = 64'h0123_4567_89AB_CDEF;
         end
         mem_rvalid = (i == 2);
         look();
         chk($sformatf("t5_mem_req%0d", i), mem_req, 1'b1);
         chk($sformatf("t5_mem_addr%0d", i), mem_addr, 32'h6000);
         chk($sformatf("t5_mem_wdata%0d", i), mem_wdata, 64'hA5A5_A5A5_0000_FFFF);
         chk($sformatf("t5_no_ready%0d", i), ls_ready, 1'b0);
         chk($sformatf("t5_no_rvalid%0d", i), ls_rvalid, 1'b0);
      end
      tick(); mem_rvalid = 0; mem_gnt = 1; look();
      chk("t5_gnt_mem_req", mem_req, 1'b1);
      tick(); mem_gnt = 0; mem_rvalid = 1; look();
      chk("t5_ls_rvalid", ls_rvalid, 1'b1);
      tick(); mem_rvalid = 0; look();
      chk("t5_second_ready", ls_ready, 1'b1);
      tick(); ls_req = 0; mem_gnt = 1; look();
      chk("t5_second_addr", mem_addr, 32'h6008);
      tick(); mem_gnt = 0; mem_rvalid = 1; look();
      chk("t5_second_rvalid", ls_rvalid, 1'b1);
      tick(); mem_rvalid = 0; look();

      // 6: reset while waiting for an LS response
      tick(); ls_req = 1; ls_we = 0; ls_addr = 32'h7000; look();
      chk("t6_ls_ready", ls_ready, 1'b1);
      tick(); ls_req = 0; mem_gnt = 1; look();
      tick(); mem_gnt = 0; rst = 1; look();
      chk("t6_wait_busy", busy, 1'b1);
      tick(); rst = 0; look();
      chk("t6_busy", busy, 1'b0);
      chk("t6_mem_req", mem_req, 1'b0);
      tick(); mem_rvalid = 1; mem_rdata = 64'h77; look();
      chk("t6_no_rvalid", ls_rvalid, 1'b0);
      tick(); mem_rvalid = 0; look();
      chk("t6_idle", busy, 1'b0);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
